// File: rtl/hidden_layer_seq.sv
// Hidden-layer sequencer: per neuron loads the bias, runs a dot product over the
// weight/input memories, then writes one ReLU-scaled, saturated activation.
module hidden_layer_seq #(
    parameter int N_NEURONS  = 30,
    parameter int N_INPUTS   = 62,
    parameter int DW         = 8,
    parameter int ACC_W      = 24,
    parameter int BIAS_SHIFT = 0,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   stall,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(N_NEURONS)-1:0]           bias_idx,
    input  logic [DW-1:0]                          bias_data,
    output logic [$clog2(N_NEURONS*N_INPUTS)-1:0]  w_addr,
    input  logic [DW-1:0]                          w_data,
    output logic [$clog2(N_INPUTS)-1:0]            x_addr,
    input  logic [DW-1:0]                          x_data,
    output logic                                   out_valid,
    output logic [$clog2(N_NEURONS)-1:0]           out_idx,
    output logic [DW-1:0]                          out_data
);

    localparam int NW  = $clog2(N_NEURONS);
    localparam int WAW = $clog2(N_NEURONS*N_INPUTS);
    localparam int XW  = $clog2(N_INPUTS);
    localparam int PW  = 2*DW;

    localparam logic [NW-1:0]           LAST_N  = NW'(N_NEURONS-1);
    localparam logic [XW-1:0]           LAST_I  = XW'(N_INPUTS-1);
    localparam logic [DW-1:0]           OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW-1)) - 1);

    typedef enum logic [2:0] {IDLE, BIAS, MAC, WRITE, FIN} state_t;

    state_t                   state, state_nx;
    logic [NW-1:0]            neuron, neuron_nx;
    logic [XW-1:0]            idx, idx_nx;
    logic [WAW-1:0]           waddr, waddr_nx;
    logic signed [ACC_W-1:0]  acc, acc_nx;
    logic [DW-1:0]            hold_q, hold_nx;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  relu_v;
    logic signed [ACC_W-1:0]  shifted;
    logic [DW-1:0]            act;

    always_comb begin
        prod     = $signed(w_data) * $signed(x_data);
        prod_ext = ACC_W'(prod);
        bias_ext = ACC_W'($signed(bias_data)) <<< BIAS_SHIFT;
        relu_v   = acc[ACC_W-1] ? '0 : acc;
        shifted  = relu_v >>> OUT_SHIFT;
        act      = (shifted > SAT_MAX) ? OUT_MAX : shifted[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            neuron <= '0;
            idx    <= '0;
            waddr  <= '0;
            acc    <= '0;
            hold_q <= '0;
        end else begin
            state  <= state_nx;
            neuron <= neuron_nx;
            idx    <= idx_nx;
            waddr  <= waddr_nx;
            acc    <= acc_nx;
            hold_q <= hold_nx;
        end
    end

    // Strobes are gated by stall so a frozen WRITE/FIN never emits them twice.
    always_comb begin
        state_nx  = state;
        neuron_nx = neuron;
        idx_nx    = idx;
        waddr_nx  = waddr;
        acc_nx    = acc;
        hold_nx   = hold_q;
        out_valid = 1'b0;
        done      = 1'b0;
        if (!stall) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx  = BIAS;
                        neuron_nx = '0;
                        idx_nx    = '0;
                        waddr_nx  = '0;
                    end
                end
                BIAS: begin
                    acc_nx   = bias_ext;
                    state_nx = MAC;
                end
                MAC: begin
                    acc_nx   = acc + prod_ext;
                    waddr_nx = waddr + WAW'(1);
                    if (idx == LAST_I) begin
                        state_nx = WRITE;
                    end else begin
                        idx_nx = idx + XW'(1);
                    end
                end
                WRITE: begin
                    out_valid = 1'b1;
                    hold_nx   = act;
                    if (neuron == LAST_N) begin
                        state_nx = FIN;
                    end else begin
                        neuron_nx = neuron + NW'(1);
                        idx_nx    = '0;
                        state_nx  = BIAS;
                    end
                end
                FIN: begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // During WRITE the activation comes straight from acc; afterwards the latched copy holds it.
    always_comb begin
        busy     = (state == BIAS) || (state == MAC) || (state == WRITE);
        bias_idx = neuron;
        out_idx  = neuron;
        x_addr   = idx;
        w_addr   = waddr;
        out_data = (state == WRITE) ? act : hold_q;
    end

endmodule

// File: doc/hidden_layer_seq.md
Name: hidden_layer_seq

Overview:
- Sequencer for one hidden layer of the feed-forward network.
- For each neuron it:
  - selects the neuron's bias from the hidden-bias ROM;
  - walks the weight and input memories and accumulates the dot product;
  - adds the bias, applies ReLU, scales and saturates the result;
  - emits one 8-bit activation per neuron on a write strobe.
- Sits between the bias/weight/input memories and the hidden activation register file. The top-level controller drives it with a start/done handshake.

Parameters:
- N_NEURONS, 30, neurons in the layer; equals the bias ROM depth.
- N_INPUTS, 62, inputs per neuron; weights stored neuron-major.
- DW, 8, width of bias, weight, input and output.
- ACC_W, 24, accumulator width (signed).
- BIAS_SHIFT, 0, left shift applied to bias before it is added.
- OUT_SHIFT, 0, arithmetic right shift applied after ReLU.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  starts one layer pass; sampled only in IDLE.
- stall  in  1  freezes all state and outputs while high.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the pass completes.
- bias_idx  out  $clog2(N_NEURONS)  index of the current neuron's bias.
- bias_data  in  DW  signed bias; combinational from the ROM, valid in the same cycle.
- w_addr  out  $clog2(N_NEURONS*N_INPUTS)  weight address, neuron*N_INPUTS+i.
- w_data  in  DW  signed weight; combinational.
- x_addr  out  $clog2(N_INPUTS)  input address i.
- x_data  in  DW  signed input; combinational.
- out_valid  out  1  activation write strobe, one cycle per neuron.
- out_idx  out  $clog2(N_NEURONS)  neuron index for the write.
- out_data  out  DW  activation, range 0..2^(DW-1)-1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters 0; acc=0.
  - busy, done and out_valid are 0; bias_idx, w_addr, x_addr, out_idx and out_data are 0.
  - Reset asserted mid-pass aborts the pass immediately. No out_valid or done follows.
- FSM states: IDLE, BIAS, MAC, WRITE, FIN.
  - IDLE: start=1 -> BIAS, with neuron=0, i=0 and w_addr=0. busy goes high next cycle.
  - BIAS (1 cycle):
    - bias_idx = neuron.
    - acc <= sext(bias_data) << BIAS_SHIFT.
    - Next state is MAC.
  - MAC (N_INPUTS cycles):
    - acc <= acc + sext(w_data*x_data), a 2*DW-bit signed product.
    - x_addr=i and w_addr advance by 1 each cycle; w_addr is a running counter with no multiplier.
    - After i=N_INPUTS-1 the next state is WRITE.
  - WRITE (1 cycle):
    - out_valid=1, out_idx=neuron.
    - out_data = sat(relu(acc) >>> OUT_SHIFT). relu(acc) is 0 if acc<0. The result saturates to 2^(DW-1)-1.
    - If neuron=N_NEURONS-1 the next state is FIN; otherwise neuron++, i=0, next state BIAS.
    - out_data holds its value until the next WRITE.
  - FIN (1 cycle): done=1, busy=0, next state IDLE.
- Timing (no stall):
  - Cycle 0 is the cycle start is sampled.
  - out_valid for neuron k is in cycle (k+1)*(N_INPUTS+2).
  - done is in cycle N_NEURONS*(N_INPUTS+2)+1.
- Handshake and stall:
  - start is ignored while busy or in FIN.
  - start in the same cycle as done is ignored.
  - stall=1 holds the state, counters, acc and all outputs.
  - A strobe (out_valid or done) is not repeated or extended by stall. It is presented in the first unstalled cycle of WRITE or FIN only, and memories are re-read when stall releases.
- Accumulator: it does not wrap at the default parameters (max |sum| < 2^22). Overflow for larger N_INPUTS is the integrator's responsibility.

Test Plan:
- Default params, bias ROM with bias0=0x34 (52), all w=1, x=2, N_INPUTS=4 -> out_idx 0, out_data=60 in cycle 6; done in cycle 181.
- bias_idx=2 (0x91=-111), w=1, x=2, N_INPUTS=4 -> acc=-103, out_data=0 at out_idx 2 in cycle 18.
- w=127, x=127, N_INPUTS=4, bias 52 -> acc=64568, out_data=127 (saturated). With OUT_SHIFT=9 -> out_data=126.
- Assert stall for 3 cycles during neuron 0 MAC (N_INPUTS=4) -> out_valid for neuron 0 moves from cycle 6 to cycle 9; out_data unchanged; exactly 30 strobes total.
- Pulse start again at cycle 50 and in the done cycle -> both ignored; exactly one done pulse; busy=0 after done.
- Drop rst_n in cycle 40 -> all outputs 0 asynchronously; no further out_valid or done. A new start after release restarts at neuron 0 with w_addr=0.
